md_sched: RTL
=============

// Module: md_sched
// PURPOSE
//  Multi-cycle multiply/divide scheduler beside the E stage. Accepts one mult/div op at a time,
//  holds the HI/LO registers and models a fixed execution latency. Raises busy while the op runs.
//  Raises stall_md so the hazard logic freezes F/D whenever a D-stage instruction touches HI/LO during an op.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (and madd family); must be >= 1
//  DIV_CYCLES   10  busy cycles for div/divu; must be >= 1
// PORTS
//  clk       in   1   clock; single clock domain, all state updates on rising edge
//  reset     in   1   synchronous, active-high reset
//  md_start  in   1   E-stage instruction is a mult/div-class op this cycle
//  md_op     in   3   op select, codes from md_pkg (MULT,MULTU,DIV,DIVU[,MADD,MADDU,MSUB,MSUBU])
//  md_a      in   32  operand A (rs, forwarded)
//  md_b      in   32  operand B (rt, forwarded)
//  hi_we     in   1   mthi in E stage
//  lo_we     in   1   mtlo in E stage
//  hilo_wd   in   32  write data for mthi/mtlo
//  md_use_D  in   1   D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
//  busy      out  1   op in progress
//  stall_md  out  1   md_use_D & (md_start | busy); combinational
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - Reset: state IDLE, cnt=0, busy=0, hi=0, lo=0. Reset mid-op aborts the op; no result is committed.
//  - FSM IDLE->RUN on md_start with a valid op in IDLE (edge T). Operands and op are latched at T.
//    cnt loads MULT_CYCLES or DIV_CYCLES.
//  - RUN: busy=1 for cycles T+1..T+N, cnt decrements each edge.
//    On the edge closing cycle T+N: commit HI/LO, go IDLE. New hi/lo are visible and busy=0 from cycle T+N+1.
//  - mult: {hi,lo} = signed 64b product. multu: unsigned.
//  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//    divu: unsigned. INT_MIN / -1 -> lo=0x80000000, hi=0.
//  - Divide by zero: full DIV_CYCLES latency, busy asserted, hi/lo left unchanged.
//  - md_start while busy: ignored. The pipeline never issues it because stall_md holds the instr in D.
//  - hi_we/lo_we in IDLE: write hilo_wd on that edge. Ignored while busy.
//    Same cycle as md_start: md_start wins and the write is dropped.
//  - hi_we & lo_we together: both take hilo_wd.
//  - Undefined md_op with md_start: no start, busy stays 0.
// CONFIGURATION
//  MD_MADD_EN defined:
//    - Adds MADD/MADDU/MSUB/MSUBU. {hi,lo} <= {hi,lo} +/- product (signed/unsigned), 64b wrap.
//    - Uses MULT_CYCLES. The accumulate base is the {hi,lo} value latched at start.
//  MD_MADD_EN undefined: those codes are undefined ops (no start, no effect).
// STRUCTURE
//  - md_pkg: op code localparams (3b), FSM state codes (IDLE, RUN), counter width derived from max(MULT_CYCLES, DIV_CYCLES).
//  - Sub-module md_core: combinational 64b result from latched op/operands/old hi-lo, plus a div_by_zero flag.
//  - md_sched owns the FSM, counter, HI/LO registers and stall logic.
// TESTING
//  1 reset; mult a=0xFFFFFFFF b=2 at T -> busy T+1..T+5; at T+6 hi=0xFFFFFFFF lo=0xFFFFFFFE.
//  2 multu a=0xFFFFFFFF b=2 -> after 5 busy cycles hi=0x00000001 lo=0xFFFFFFFE.
//  3 div a=-7 b=2 -> busy 10 cycles; lo=0xFFFFFFFD hi=0xFFFFFFFF. divu 7/2 -> lo=3 hi=1.
//  4 mthi 0x1234 then divu 7/0 -> busy 10 cycles; hi stays 0x1234, lo unchanged.
//  5 mult running, md_use_D=1, md_start=1, hi_we=1 -> stall_md=1 every busy cycle;
//    second start and mthi ignored; result from first op only.
//  6 div started, reset asserted in busy cycle 3 -> next cycle busy=0, hi=lo=0, stall_md=0.
//  7 (MD_MADD_EN) hi=0 lo=0xFFFFFFFF, maddu 1*1 -> hi=1 lo=0; without macro, same op -> no busy, no change.

Source files
------------

// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide scheduler:
//   - 3-bit op codes for md_op
//   - FSM state encoding (IDLE, RUN)
//   - default latencies and a helper that sizes the cycle counter
//   - op_valid(): decides which op codes may start an operation
// Configuration macro: MD_MADD_EN
//   When defined, MADD/MADDU/MSUB/MSUBU are legal ops. When undefined,
//   those codes are treated as undefined and never start an operation.
// ---------------------------------------------------------------------------
package md_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] OP_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] OP_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] OP_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] OP_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] OP_MADD  = 3'd4;
    localparam logic [MD_OP_W-1:0] OP_MADDU = 3'd5;
    localparam logic [MD_OP_W-1:0] OP_MSUB  = 3'd6;
    localparam logic [MD_OP_W-1:0] OP_MSUBU = 3'd7;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // Counter must hold the larger of the two latencies.
    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int m;
        m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

    function automatic logic op_valid(input logic [MD_OP_W-1:0] op);
`ifdef MD_MADD_EN
        return 1'b1;
`else
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
`endif
    endfunction

    function automatic logic op_is_div(input logic [MD_OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// ---------------------------------------------------------------------------
// md_core
// Purely combinational result generator for the latched mult/div operation.
// Ports:
//   op          in  3   latched op code
//   a, b        in  32  latched operands
//   hi_old      in  32  accumulate base (HI) for the madd family
//   lo_old      in  32  accumulate base (LO) for the madd family
//   result      out 64  {hi,lo} value to commit
//   div_by_zero out 1   divide op with b == 0; caller must not commit
// The madd/msub arms are always present here; whether those codes may start
// is decided by op_valid() in the scheduler (MD_MADD_EN).
// ---------------------------------------------------------------------------
module md_core
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic [31:0]        hi_old,
    input  logic [31:0]        lo_old,
    output logic [63:0]        result,
    output logic               div_by_zero
);

    logic        signed_op;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV) ||
                       (op == OP_MADD) || (op == OP_MSUB);

    // Sign/zero extension to 64 bits makes the low 64 bits of a plain
    // product correct for both signed and unsigned operands.
    assign a_ext = signed_op ? {{32{a[31]}}, a} : {32'd0, a};
    assign b_ext = signed_op ? {{32{b[31]}}, b} : {32'd0, b};
    assign prod  = a_ext * b_ext;

    // Signed divide through magnitudes: quotient truncates toward zero,
    // remainder follows the dividend. INT_MIN / -1 yields magnitude
    // 0x80000000 with no negation, which is the required wrapped result.
    assign a_neg   = signed_op & a[31];
    assign b_neg   = signed_op & b[31];
    assign a_mag   = a_neg ? (32'd0 - a) : a;
    assign b_mag   = b_neg ? (32'd0 - b) : b;
    assign divisor = (b == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

    assign div_by_zero = op_is_div(op) && (b == 32'd0);

    always_comb begin
        result = prod;
        case (op)
            OP_MULT, OP_MULTU: result = prod;
            OP_DIV,  OP_DIVU:  result = {rem, quot};
            OP_MADD, OP_MADDU: result = {hi_old, lo_old} + prod;
            OP_MSUB, OP_MSUBU: result = {hi_old, lo_old} - prod;
            default:           result = prod;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched
// Multi-cycle multiply/divide scheduler beside the E stage. Holds HI/LO,
// models a fixed latency per op class and raises stall_md so F/D freeze
// while a D-stage instruction touches HI/LO during an operation.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   md_start, md_op    start request and op code from E
//   md_a, md_b         forwarded operands
//   hi_we, lo_we       mthi / mtlo in E, data on hilo_wd
//   md_use_D           D-stage instruction uses the mult/div unit
//   busy               operation in progress
//   stall_md           md_use_D & (md_start | busy), combinational
//   hi, lo             architectural HI/LO registers
//   dbg_state          current FSM state
// Handshake: md_start is accepted only on an edge where busy is low and
// md_op is a legal op; there is no back-pressure signal, so a request
// presented while busy is simply dropped (the pipeline never does this
// because stall_md holds the instruction in D).
// Configuration macro: MD_MADD_EN (enables the madd/msub family).
// ---------------------------------------------------------------------------
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               md_start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        md_a,
    input  logic [31:0]        md_b,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [31:0]        hilo_wd,
    input  logic               md_use_D,
    output logic               busy,
    output logic               stall_md,
    output logic [31:0]        hi,
    output logic [31:0]        lo,
    output md_state_t          dbg_state
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_t          state_q;
    md_state_t          state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [MD_OP_W-1:0] op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [63:0]        core_result;
    logic               core_div0;
    logic               start_go;
    logic               last_cycle;

    assign start_go   = (state_q == ST_IDLE) && md_start && op_valid(md_op);
    assign last_cycle = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

    // HI/LO cannot change while RUN (writes are ignored), so the live
    // registers are exactly the accumulate base captured at start.
    md_core u_core (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
        .hi_old      (hi_q),
        .lo_old      (lo_q),
        .result      (core_result),
        .div_by_zero (core_div0)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_go)   state_d = ST_RUN;
            ST_RUN:  if (last_cycle) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (state_q == ST_RUN);
        dbg_state = state_q;
    end

    assign stall_md = md_use_D & (md_start | busy);
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Datapath: operand latch, latency counter, HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (state_q == ST_IDLE) begin
            if (start_go) begin
                op_q  <= md_op;
                a_q   <= md_a;
                b_q   <= md_b;
                cnt_q <= op_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else begin
                if (hi_we) hi_q <= hilo_wd;
                if (lo_we) lo_q <= hilo_wd;
            end
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_cycle && !core_div0) begin
                hi_q <= core_result[63:32];
                lo_q <= core_result[31:0];
            end
        end
    end

endmodule
